// File: rtl/clock_pkg.sv
// clock_pkg: BCD digit types, wrap limits and digit-pair helpers shared by the clock RTL.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  // Tens/units pair of one hh, mm or ss field.
  typedef struct packed {
    bcd_t t;
    bcd_t u;
  } bcd2_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MAX = 12;

  // True when the digit pair reads the decimal value val (0..99).
  function automatic logic bcd2_is(bcd2_t x, int val);
    return (x.t == bcd_t'(val / 10)) && (x.u == bcd_t'(val % 10));
  endfunction

  // Decimal +1 with units carry into tens; callers handle the field wrap.
  function automatic bcd2_t bcd2_inc(bcd2_t x);
    bcd2_t r;
    if (x.u == 4'd9) begin
      r.t = x.t + 4'd1;
      r.u = 4'd0;
    end else begin
      r.t = x.t;
      r.u = x.u + 4'd1;
    end
    return r;
  endfunction

  // Decimal +1 that wraps max back to 00.
  function automatic bcd2_t bcd2_wrap(bcd2_t x, int max);
    bcd2_t r;
    if (bcd2_is(x, max)) begin
      r = '0;
    end else begin
      r = bcd2_inc(x);
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler counting 0..CLK_HZ-1, strobing tick on the last count of each second.
// Latency: tick is combinational from the prescaler flop; first tick CLK_HZ cycles after reset or set-mode exit.
// Backpressure: none; set_mode holds the prescaler at 0 and suppresses tick.
// Ports: clk, rst_n (async active-low), set_mode (hold), tick (advance strobe, valid in the cycle before the edge).
import clock_pkg::*;

module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_mode,
  output logic tick
);

  localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] prescale_q;
  logic [CW-1:0] prescale_d;

  always_comb begin
    prescale_d = prescale_q + 1'b1;
    tick       = 1'b0;
    if (set_mode) begin
      prescale_d = '0;
    end else if (prescale_q == LAST) begin
      prescale_d = '0;
      tick       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_d;
    end
  end

endmodule

// File: rtl/time_counter.sv
// time_counter: hh:mm:ss BCD time-of-day clock with a frozen set mode for adjusting hours/minutes.
// Latency: all digits, pm and tick_1hz are registered and update on the edge where the prescaler wraps.
// Backpressure: none; inc_min/inc_hour act every cycle they are high in set mode and are ignored otherwise.
// Ports: clk, rst_n (async active-low), set_mode, inc_min, inc_hour in; hr_t/hr_u/min_t/min_u/sec_t/sec_u
//        (BCD digits), tick_1hz (one cycle after each second advance), pm out.
// Build option: define TIME_COUNTER_12H_EN for a 12,01..11 hour display with pm; default is 00..23, pm tied 0.
import clock_pkg::*;

module time_counter #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [3:0] hr_t,
  output logic [3:0] hr_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic       tick_1hz,
  output logic       pm
);

`ifdef TIME_COUNTER_12H_EN
  localparam bcd2_t HR_RST = '{t: 4'd1, u: 4'd2};
`else
  localparam bcd2_t HR_RST = '0;
`endif

  logic  tick;
  logic  hr_adv;
  bcd2_t sec_q, sec_d;
  bcd2_t min_q, min_d;
  bcd2_t hr_q, hr_d;
  logic  tick_1hz_q, tick_1hz_d;

  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_mode (set_mode),
    .tick     (tick)
  );

  // Seconds/minutes chain; hr_adv is the single request to step the hour field,
  // shared by the minute carry and the set-mode button.
  always_comb begin
    sec_d      = sec_q;
    min_d      = min_q;
    hr_adv     = 1'b0;
    tick_1hz_d = 1'b0;
    if (set_mode) begin
      sec_d = '0;
      if (inc_min) begin
        min_d = bcd2_wrap(min_q, MIN_MAX);
      end
      hr_adv = inc_hour;
    end else if (tick) begin
      tick_1hz_d = 1'b1;
      sec_d      = bcd2_wrap(sec_q, SEC_MAX);
      if (bcd2_is(sec_q, SEC_MAX)) begin
        min_d = bcd2_wrap(min_q, MIN_MAX);
        if (bcd2_is(min_q, MIN_MAX)) begin
          hr_adv = 1'b1;
        end
      end
    end
  end

`ifdef TIME_COUNTER_12H_EN
  logic pm_q, pm_d;

  // 12 -> 01 keeps the half of day; 11 -> 12 is the noon/midnight crossing.
  always_comb begin
    hr_d = hr_q;
    pm_d = pm_q;
    if (hr_adv) begin
      if (bcd2_is(hr_q, HR12_MAX)) begin
        hr_d = '{t: 4'd0, u: 4'd1};
      end else if (bcd2_is(hr_q, HR12_MAX - 1)) begin
        hr_d = '{t: 4'd1, u: 4'd2};
        pm_d = ~pm_q;
      end else begin
        hr_d = bcd2_inc(hr_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q <= 1'b0;
    end else begin
      pm_q <= pm_d;
    end
  end

  assign pm = pm_q;
`else
  always_comb begin
    hr_d = hr_q;
    if (hr_adv) begin
      hr_d = bcd2_wrap(hr_q, HR24_MAX);
    end
  end

  assign pm = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= HR_RST;
      tick_1hz_q <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      tick_1hz_q <= tick_1hz_d;
    end
  end

  assign hr_t     = hr_q.t;
  assign hr_u     = hr_q.u;
  assign min_t    = min_q.t;
  assign min_u    = min_q.u;
  assign sec_t    = sec_q.t;
  assign sec_u    = sec_q.u;
  assign tick_1hz = tick_1hz_q;

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, giving clk cycles per second (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port set_mode, input, 1 bit; high = time-set mode (count frozen).
REQ-005 The block SHALL have port inc_min, input, 1 bit; single-cycle pulse, already debounced and synchronized, advancing minutes in set mode.
REQ-006 The block SHALL have port inc_hour, input, 1 bit; single-cycle pulse, already debounced and synchronized, advancing hours in set mode.
REQ-007 The block SHALL have ports hr_t, hr_u, min_t, min_u, sec_t, sec_u, each output, 4 bits, each one BCD digit for the 7-segment decoder stage.
REQ-008 The block SHALL have port tick_1hz, output, 1 bit; one-cycle pulse marking each second boundary.
REQ-009 The block SHALL have port pm, output, 1 bit; PM indicator.

Function
REQ-010 Prescaler SHALL count 0..CLK_HZ-1 and wrap to 0; a second advance SHALL occur on the edge where prescaler = CLK_HZ-1.
REQ-011 tick_1hz SHALL be registered and high for exactly the one cycle after each second advance.
REQ-012 Seconds SHALL count 00..59; 59 SHALL wrap to 00 with a carry to minutes on the same edge.
REQ-013 Minutes SHALL count 00..59; 59 with a carry SHALL wrap to 00 with a carry to hours on the same edge.
REQ-014 All digit outputs SHALL be registered and SHALL only ever hold 0..9; tens digits SHALL never exceed 5 (sec_t, min_t) or 2 (hr_t).
REQ-015 While set_mode = 1: prescaler held at 0, seconds forced to 00, tick_1hz = 0, no carries.
REQ-016 In set mode, inc_min SHALL advance minutes by 1 with 59 wrapping to 00 and no hour carry.
REQ-017 In set mode, inc_hour SHALL advance hours by 1 with the mode's wrap and no other digit affected.
REQ-018 inc_min and inc_hour asserted in the same cycle SHALL both take effect in that cycle.
REQ-019 inc_min and inc_hour SHALL be ignored while set_mode = 0.
REQ-020 When set_mode falls, counting SHALL resume from prescaler 0; the first advance SHALL occur CLK_HZ cycles later.
REQ-021 An inc pulse held high for N cycles SHALL produce N increments; no edge detection is performed.

Reset
REQ-022 rst_n low SHALL immediately clear the prescaler and set tick_1hz = 0, seconds 00 and minutes 00, regardless of clk.
REQ-023 Reset hours SHALL be 00 with pm = 0 (24 h build) or 12 with pm = 0 (12 h build).
REQ-024 Reset asserted mid-count or mid-set SHALL discard all state; after release, the first advance SHALL occur CLK_HZ cycles later.

Configuration
REQ-025 Macro TIME_COUNTER_12H_EN SHALL select the hour format.
REQ-026 Without the macro: hours SHALL be 00..23, 23:59:59 SHALL roll over to 00:00:00, and pm SHALL be tied 0.
REQ-027 With the macro: hours SHALL follow 12,01..11. 11:59:59 SHALL roll over to 12:00:00 and toggle pm. 12:59:59 SHALL roll over to 01:00:00 with pm unchanged. inc_hour from 11 SHALL toggle pm.

Structure
REQ-028 Shared package clock_pkg SHALL hold the BCD digit typedef (4 bits) and constants SEC_MAX = 59, MIN_MAX = 59, HR24_MAX = 23 and HR12_MAX = 12.
REQ-029 The prescaler SHALL be one sub-module, tick_gen, parameterized by CLK_HZ, with outputs tick and hold input set_mode.
REQ-030 The hh:mm:ss BCD chain SHALL reside in time_counter itself.

Verification (CLK_HZ = 4)
REQ-031 Release reset and run 8 cycles -> tick_1hz pulses at cycles 4 and 8; sec_u goes 0 -> 1 -> 2.
REQ-032 Preload 23:59:59 (24 h build), one tick -> 00:00:00 with all digits updated on the same edge.
REQ-033 set_mode = 1, minutes at 59, one inc_min pulse -> minutes 00 and hours unchanged; seconds read 00 and no tick occurs for 20 cycles.
REQ-034 inc_min and inc_hour in the same cycle at 09:14 -> 10:15; the same pulses with set_mode = 0 -> no change.
REQ-035 12 h build, preload 11:59:59, pm = 0, one tick -> 12:00:00, pm = 1; preload 12:59:59 -> 01:00:00, pm unchanged.
REQ-036 Assert rst_n low between clock edges at 05:30:17 -> outputs reset immediately without waiting for clk; after release, the first tick occurs 4 cycles later.
